// File: rtl/regfile_param.sv
// regfile_param
// Parametrised CPU register file with a per-register busy scoreboard.
// Decode/issue marks registers busy and reads operands. Writeback writes
// results, and each write clears the busy bit of its register.
//
// Ports:
//   clk        - single clock; all state updates on posedge
//   reset      - asynchronous, active-low; clears storage and scoreboard
//   wr_en      - write strobe
//   wr_addr    - write register index (AW bits)
//   wr_data    - write data (WIDTH bits)
//   busy_set   - mark busy_addr as having a write in flight
//   busy_addr  - register to mark busy
//   rd_addr    - NUM_RD read indices
//   rd_data    - NUM_RD read results (combinational)
//   rd_busy    - NUM_RD busy flags for the addressed registers (combinational)
//   busy_vec   - full scoreboard, straight from the busy flops
module regfile_param #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int HAS_ZERO = 1,
    parameter int ZERO_IDX = 31,
    parameter int BYPASS   = 1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [AW-1:0]                  wr_addr,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           busy_set,
    input  logic [AW-1:0]                  busy_addr,
    input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
    output logic [NUM_RD-1:0][WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    output logic [DEPTH-1:0]               busy_vec
);

    // A register index is usable when it is in range and is not the
    // hardwired-zero register. Upper codes of a non-power-of-two DEPTH
    // fall out here.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) && !((HAS_ZERO != 0) && (int'(a) == ZERO_IDX));
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    logic wr_legal;
    logic bset_legal;

    // Qualify with reset so that nothing is written or forwarded while
    // reset is held low.
    assign wr_legal   = reset && wr_en && addr_ok(wr_addr);
    assign bset_legal = reset && busy_set && addr_ok(busy_addr);

    always_comb begin
        mem_d = mem_q;
        if (wr_legal) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // The busy set is applied after the write clear, so a new producer
    // wins over a completing write to the same register.
    always_comb begin
        busy_d = busy_q;
        if (wr_legal) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (bset_legal) begin
            busy_d[busy_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // Read ports. A legal same-cycle write to the same register is
    // forwarded when BYPASS is set, and that write also ends the busy state.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (reset && addr_ok(rd_addr[p])) begin
                if ((BYPASS != 0) && wr_legal && (wr_addr == rd_addr[p])) begin
                    rd_data[p] = wr_data;
                    rd_busy[p] = 1'b0;
                end else begin
                    rd_data[p] = mem_q[rd_addr[p]];
                    rd_busy[p] = busy_q[rd_addr[p]];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Testbench for regfile_param. It drives three instances:
//   a: default parameters (bypass on)
//   b: BYPASS=0, with the same stimulus as a
//   c: WIDTH=32, DEPTH=20, NUM_RD=3
// The driver computes the expected read results from an array model and
// pushes them into a queue. A monitor pops the queue on each negedge and
// compares the entries against the DUT outputs.
module tb_regfile_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // instances a and b
    logic             ab_wr_en, ab_busy_set;
    logic [4:0]       ab_wr_addr, ab_busy_addr;
    logic [63:0]      ab_wr_data;
    logic [1:0][4:0]  ab_rd_addr;
    logic [1:0][63:0] a_rd_data, b_rd_data;
    logic [1:0]       a_rd_busy, b_rd_busy;
    logic [31:0]      a_busy_vec, b_busy_vec;

    // instance c
    logic             c_wr_en, c_busy_set;
    logic [4:0]       c_wr_addr, c_busy_addr;
    logic [31:0]      c_wr_data;
    logic [2:0][4:0]  c_rd_addr;
    logic [2:0][31:0] c_rd_data;
    logic [2:0]       c_rd_busy;
    logic [19:0]      c_busy_vec;

    regfile_param u_a (
        .clk(clk), .reset(reset), .wr_en(ab_wr_en), .wr_addr(ab_wr_addr),
        .wr_data(ab_wr_data), .busy_set(ab_busy_set), .busy_addr(ab_busy_addr),
        .rd_addr(ab_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .busy_vec(a_busy_vec)
    );

    regfile_param #(.BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .wr_en(ab_wr_en), .wr_addr(ab_wr_addr),
        .wr_data(ab_wr_data), .busy_set(ab_busy_set), .busy_addr(ab_busy_addr),
        .rd_addr(ab_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .busy_vec(b_busy_vec)
    );

    regfile_param #(.WIDTH(32), .DEPTH(20), .NUM_RD(3)) u_c (
        .clk(clk), .reset(reset), .wr_en(c_wr_en), .wr_addr(c_wr_addr),
        .wr_data(c_wr_data), .busy_set(c_busy_set), .busy_addr(c_busy_addr),
        .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
        .busy_vec(c_busy_vec)
    );

    typedef struct {
        int          dut;
        int          port;
        int          cyc;
        logic [63:0] data;
        logic        busy;
        logic [31:0] bvec;
    } exp_t;

    exp_t sq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // reference model state
    logic [63:0] m  [32];
    bit          bz [32];
    logic [31:0] cm [20];
    bit          cbz[20];

    // staged stimulus, applied just after the next posedge
    bit          s_rst;
    bit          s_we, s_bs;
    logic [4:0]  s_wa, s_ba;
    logic [63:0] s_wd;
    logic [4:0]  s_ra[2];
    bit          cs_we, cs_bs;
    logic [4:0]  cs_wa, cs_ba;
    logic [31:0] cs_wd;
    logic [4:0]  cs_ra[3];

    task automatic step();
        exp_t        e;
        logic [31:0] bv;
        logic [4:0]  a;
        bit          lw, lcw;
        @(posedge clk);
        #1;
        cyc++;
        reset        = s_rst;
        ab_wr_en     = s_we;
        ab_wr_addr   = s_wa;
        ab_wr_data   = s_wd;
        ab_busy_set  = s_bs;
        ab_busy_addr = s_ba;
        for (int p = 0; p < 2; p++) ab_rd_addr[p] = s_ra[p];
        c_wr_en      = cs_we;
        c_wr_addr    = cs_wa;
        c_wr_data    = cs_wd;
        c_busy_set   = cs_bs;
        c_busy_addr  = cs_ba;
        for (int p = 0; p < 3; p++) c_rd_addr[p] = cs_ra[p];

        // a / b expectations (32 regs, reg 31 reads as zero)
        lw = s_rst && s_we && (s_wa != 5'd31);
        bv = '0;
        for (int i = 0; i < 32; i++) bv[i] = s_rst ? bz[i] : 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                a = s_ra[p];
                e.dut = d; e.port = p; e.cyc = cyc; e.bvec = bv;
                if (!s_rst || a == 5'd31) begin
                    e.data = '0; e.busy = 1'b0;
                end else if (d == 0 && lw && s_wa == a) begin
                    e.data = s_wd; e.busy = 1'b0;
                end else begin
                    e.data = m[a]; e.busy = bz[a];
                end
                sq.push_back(e);
            end
        end

        // c expectations (20 regs, codes 20..31 out of range)
        lcw = s_rst && cs_we && (cs_wa < 5'd20);
        bv = '0;
        for (int i = 0; i < 20; i++) bv[i] = s_rst ? cbz[i] : 1'b0;
        for (int p = 0; p < 3; p++) begin
            a = cs_ra[p];
            e.dut = 2; e.port = p; e.cyc = cyc; e.bvec = bv;
            if (!s_rst || a >= 5'd20) begin
                e.data = '0; e.busy = 1'b0;
            end else if (lcw && cs_wa == a) begin
                e.data = {32'h0, cs_wd}; e.busy = 1'b0;
            end else begin
                e.data = {32'h0, cm[a]}; e.busy = cbz[a];
            end
            sq.push_back(e);
        end

        // state after the coming posedge
        if (!s_rst) begin
            for (int i = 0; i < 32; i++) begin m[i] = '0; bz[i] = 1'b0; end
            for (int i = 0; i < 20; i++) begin cm[i] = '0; cbz[i] = 1'b0; end
        end else begin
            if (lw) begin m[s_wa] = s_wd; bz[s_wa] = 1'b0; end
            if (s_bs && s_ba != 5'd31) bz[s_ba] = 1'b1;
            if (lcw) begin cm[cs_wa] = cs_wd; cbz[cs_wa] = 1'b0; end
            if (cs_bs && cs_ba < 5'd20) cbz[cs_ba] = 1'b1;
        end
    endtask

    task automatic ab(input bit we, input logic [4:0] wa, input logic [63:0] wd,
                      input bit bs, input logic [4:0] ba,
                      input logic [4:0] r0, input logic [4:0] r1);
        s_we = we; s_wa = wa; s_wd = wd; s_bs = bs; s_ba = ba;
        s_ra[0] = r0; s_ra[1] = r1;
        step();
    endtask

    task automatic c_set(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
        cs_we = we; cs_wa = wa; cs_wd = wd; cs_bs = 1'b0; cs_ba = '0;
        cs_ra[0] = r0; cs_ra[1] = r1; cs_ra[2] = r2;
    endtask

    // monitor: compare every expectation queued for this cycle
    initial begin
        exp_t        e;
        logic [63:0] got_d;
        logic        got_b;
        logic [31:0] got_v;
        forever begin
            @(negedge clk);
            while (sq.size() > 0) begin
                e = sq.pop_front();
                case (e.dut)
                    0: begin got_d = a_rd_data[e.port]; got_b = a_rd_busy[e.port]; got_v = a_busy_vec; end
                    1: begin got_d = b_rd_data[e.port]; got_b = b_rd_busy[e.port]; got_v = b_busy_vec; end
                    default: begin
                        got_d = {32'h0, c_rd_data[e.port]}; got_b = c_rd_busy[e.port];
                        got_v = {12'h0, c_busy_vec};
                    end
                endcase
                checks++;
                if (got_d !== e.data) begin
                    errors++;
                    $display("FAIL rd_data dut%0d port%0d cyc%0d got=%h exp=%h", e.dut, e.port, e.cyc, got_d, e.data);
                end
                checks++;
                if (got_b !== e.busy) begin
                    errors++;
                    $display("FAIL rd_busy dut%0d port%0d cyc%0d got=%b exp=%b", e.dut, e.port, e.cyc, got_b, e.busy);
                end
                if (e.port == 0) begin
                    checks++;
                    if (got_v !== e.bvec) begin
                        errors++;
                        $display("FAIL busy_vec dut%0d cyc%0d got=%h exp=%h", e.dut, e.cyc, got_v, e.bvec);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        ab_wr_en = 1'b0; ab_wr_addr = '0; ab_wr_data = '0;
        ab_busy_set = 1'b0; ab_busy_addr = '0; ab_rd_addr = '0;
        c_wr_en = 1'b0; c_wr_addr = '0; c_wr_data = '0;
        c_busy_set = 1'b0; c_busy_addr = '0; c_rd_addr = '0;
        for (int i = 0; i < 32; i++) begin m[i] = '0; bz[i] = 1'b0; end
        for (int i = 0; i < 20; i++) begin cm[i] = '0; cbz[i] = 1'b0; end
        c_set(1'b0, 5'd0, 32'h0, 5'd0, 5'd1, 5'd2);

        // reset state
        s_rst = 1'b0;
        ab(1'b1, 5'd4, 64'd99, 1'b1, 5'd3, 5'd4, 5'd3);
        s_rst = 1'b1;
        ab(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd4, 5'd3);

        // write 4=27 and mark 7 busy, then drop reset mid-run
        ab(1'b1, 5'd4, 64'd27, 1'b1, 5'd7, 5'd4, 5'd4);
        ab(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd4, 5'd7);
        s_rst = 1'b0;
        ab(1'b1, 5'd5, 64'd55, 1'b1, 5'd5, 5'd4, 5'd5);
        s_rst = 1'b1;
        ab(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd4, 5'd7);

        // write 4=27 and read it on both ports; the zero register stays zero
        ab(1'b1, 5'd4, 64'd27, 1'b0, 5'd0, 5'd1, 5'd2);
        ab(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd4, 5'd4);
        ab(1'b1, 5'd31, 64'd1, 1'b0, 5'd0, 5'd31, 5'd4);
        ab(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd31, 5'd31);

        // same-cycle write and read of reg 0: forwarded in a, old value in b
        ab(1'b1, 5'd0, 64'h7FFF_FFFF, 1'b0, 5'd0, 5'd0, 5'd4);
        ab(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);

        // busy scoreboard on reg 7
        ab(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 5'd7, 5'd0);
        ab(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd7, 5'd7);
        ab(1'b1, 5'd7, 64'd44, 1'b0, 5'd0, 5'd7, 5'd0);
        ab(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd7, 5'd7);

        // write and busy_set of reg 9 in the same cycle; busy_set of the zero reg
        ab(1'b1, 5'd9, 64'd16, 1'b1, 5'd9, 5'd9, 5'd0);
        ab(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 5'd9, 5'd31);
        ab(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd9, 5'd31);

        // instance c: fill all 20 registers, then read each on every port
        for (int i = 0; i < 20; i++) begin
            c_set(1'b1, 5'(i), $urandom, 5'(i), 5'((i + 19) % 20), 5'd25);
            ab(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd9, 5'd4);
        end
        for (int i = 0; i < 20; i++) begin
            c_set(1'b0, 5'd0, 32'h0, 5'(i), 5'(i), 5'(i));
            ab(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd7);
        end
        // out-of-range write and read on c
        c_set(1'b1, 5'd25, 32'hDEAD_BEEF, 5'd25, 5'd5, 5'd19);
        ab(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        c_set(1'b0, 5'd0, 32'h0, 5'd25, 5'd5, 5'd19);
        ab(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);

        // randomized traffic on all instances, with occasional resets
        for (int n = 0; n < 400; n++) begin
            s_rst = ($urandom_range(0, 59) != 0);
            cs_we = $urandom_range(0, 1); cs_wa = 5'($urandom_range(0, 31)); cs_wd = $urandom;
            cs_bs = $urandom_range(0, 1); cs_ba = 5'($urandom_range(0, 31));
            for (int p = 0; p < 3; p++) cs_ra[p] = 5'($urandom_range(0, 31));
            ab($urandom_range(0, 1), 5'($urandom_range(0, 31)), {$urandom, $urandom},
               $urandom_range(0, 1), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
